// File: rtl/stage_wb_hist_pkg.sv
// Shared writeback-stage definitions: select codes, control bit positions and
// the layout of one writeback history entry.
package stage_wb_hist_pkg;

    typedef enum logic [1:0] {
        WB_SEL_MEM  = 2'b00,
        WB_SEL_ALU  = 2'b01,
        WB_SEL_PC   = 2'b10,
        WB_SEL_ZERO = 2'b11
    } wb_sel_e;

    localparam int unsigned WB_CNTRL_W      = 3;
    localparam int unsigned WB_RDST_MUX_LSB = 0;
    localparam int unsigned WB_RDST_MUX_MSB = 1;
    localparam int unsigned WB_R_WE         = 2;

    // History entry is packed as {we, rdst, data}, data in the low bits.
    function automatic int unsigned hist_ent_w(input int unsigned width, input int unsigned aw);
        return 1 + aw + width;
    endfunction

endpackage

// File: rtl/wb_hist_buf.sv
// DEPTH-entry writeback history shift buffer with stall, flush and reset.
// Entry 0 is the most recent commit; the flattened entries are exported.
module wb_hist_buf
    import stage_wb_hist_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned ENT_W = hist_ent_w(WIDTH, REG_AW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   we_i,
    input  logic [REG_AW-1:0]      rdst_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [DEPTH*ENT_W-1:0] hist_o
);

    logic [DEPTH-1:0][ENT_W-1:0] ent_q;
    logic [DEPTH-1:0][ENT_W-1:0] ent_d;

    // Flush only drops the write-enables; rdst/data are left as they were.
    always_comb begin
        ent_d = ent_q;
        if (flush_i) begin
            for (int d = 0; d < DEPTH; d++) begin
                ent_d[d][ENT_W-1] = 1'b0;
            end
        end else if (!stall_i) begin
            for (int d = DEPTH - 1; d > 0; d--) begin
                ent_d[d] = ent_q[d-1];
            end
            ent_d[0] = {we_i, rdst_i, data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign hist_o = ent_q;

endmodule

// File: rtl/stage_wb_hist.sv
// Writeback stage: register-file write data select and write port, plus a
// DEPTH-entry writeback history serving NRD youngest-first forwarding lookups.
module stage_wb_hist
    import stage_wb_hist_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned NRD     = 2,
    parameter int unsigned R0_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wb_valid,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_flush,
    input  logic [WIDTH-1:0]        i_wb_pc,
    input  logic [WIDTH-1:0]        i_wb_data_o_ma,
    input  logic [WIDTH-1:0]        i_wb_alu_rslt,
    input  logic [WB_CNTRL_W-1:0]   i_wb_cntrl,
    input  logic [REG_AW-1:0]       i_wb_rdst,
    output logic [REG_AW-1:0]       o_wb_rdst,
    output logic                    o_wb_reg_write_rf,
    output logic [WIDTH-1:0]        o_wb_mux,
    output logic [1:0]              o_wb_reg_dst_s,
    output logic [REG_AW-1:0]       o_vwb_rdst,
    output logic                    o_vwb_reg_write_rf,
    output logic [WIDTH-1:0]        o_vwb_mux,
    input  logic [NRD*REG_AW-1:0]   i_fwd_rs,
    output logic [NRD-1:0]          o_fwd_hit,
    output logic [NRD*WIDTH-1:0]    o_fwd_data
);

    localparam int unsigned ENT_W = hist_ent_w(WIDTH, REG_AW);

    if (DEPTH < 1 || DEPTH > 8 || NRD < 1) begin : g_param_err
        $error("stage_wb_hist: DEPTH must be in 1..8 and NRD must be >= 1");
    end

    logic                   r0_block;
    logic                   commit_we;
    logic [WIDTH-1:0]       wb_mux;
    logic [DEPTH*ENT_W-1:0] hist_flat;
    logic [DEPTH-1:0]       hist_we;
    logic [REG_AW-1:0]      hist_rdst [DEPTH];
    logic [WIDTH-1:0]       hist_data [DEPTH];

    // Register-file write data select.
    always_comb begin
        wb_mux = '0;
        case (wb_sel_e'(i_wb_cntrl[WB_RDST_MUX_MSB:WB_RDST_MUX_LSB]))
            WB_SEL_MEM:  wb_mux = i_wb_data_o_ma;
            WB_SEL_ALU:  wb_mux = i_wb_alu_rslt;
            WB_SEL_PC:   wb_mux = i_wb_pc;
            WB_SEL_ZERO: wb_mux = '0;
            default:     wb_mux = '0;
        endcase
    end

    assign r0_block  = (R0_ZERO != 0) && (i_wb_rdst == '0);
    assign commit_we = i_wb_cntrl[WB_R_WE] & i_wb_valid & ~r0_block;

    assign o_wb_rdst         = i_wb_rdst;
    assign o_wb_reg_write_rf = commit_we;
    assign o_wb_mux          = wb_mux;
    assign o_wb_reg_dst_s    = i_wb_cntrl[WB_RDST_MUX_MSB:WB_RDST_MUX_LSB];

    wb_hist_buf #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .stall_i (i_wb_stall),
        .flush_i (i_wb_flush),
        .we_i    (commit_we),
        .rdst_i  (i_wb_rdst),
        .data_i  (wb_mux),
        .hist_o  (hist_flat)
    );

    for (genvar d = 0; d < DEPTH; d++) begin : g_unpack
        assign hist_we[d]   = hist_flat[d*ENT_W + ENT_W - 1];
        assign hist_rdst[d] = hist_flat[d*ENT_W + WIDTH +: REG_AW];
        assign hist_data[d] = hist_flat[d*ENT_W +: WIDTH];
    end

    assign o_vwb_reg_write_rf = hist_we[0];
    assign o_vwb_rdst         = hist_rdst[0];
    assign o_vwb_mux          = hist_data[0];

    // Oldest candidate first so that each younger match overrides it.
    for (genvar p = 0; p < NRD; p++) begin : g_fwd
        logic [REG_AW-1:0] rs;
        logic              hit;
        logic [WIDTH-1:0]  data;

        assign rs = i_fwd_rs[p*REG_AW +: REG_AW];

        always_comb begin
            hit  = 1'b0;
            data = '0;
            for (int d = DEPTH - 1; d >= 0; d--) begin
                if (hist_we[d] && (hist_rdst[d] == rs)) begin
                    hit  = 1'b1;
                    data = hist_data[d];
                end
            end
            if (commit_we && (i_wb_rdst == rs)) begin
                hit  = 1'b1;
                data = wb_mux;
            end
            if ((R0_ZERO != 0) && (rs == '0)) begin
                hit  = 1'b0;
                data = '0;
            end
        end

        assign o_fwd_hit[p]               = hit;
        assign o_fwd_data[p*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_stage_wb_hist.sv
// Self-checking bench for stage_wb_hist: directed scenarios plus randomized
// traffic compared against a queue-based model of the writeback history.
module tb_stage_wb_hist;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned D  = 2;
    localparam int unsigned N  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, valid, stall, flush;
    logic [W-1:0]    pc, mem, alu;
    logic [2:0]      cntrl;
    logic [AW-1:0]   rdst;
    logic [N*AW-1:0] fwd_rs;

    logic [AW-1:0]   o_wb_rdst, o_vwb_rdst;
    logic            o_wb_reg_write_rf, o_vwb_reg_write_rf;
    logic [W-1:0]    o_wb_mux, o_vwb_mux;
    logic [1:0]      o_wb_reg_dst_s;
    logic [N-1:0]    o_fwd_hit;
    logic [N*W-1:0]  o_fwd_data;

    stage_wb_hist #(.WIDTH(W), .REG_AW(AW), .DEPTH(D), .NRD(N), .R0_ZERO(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_wb_valid         (valid),
        .i_wb_stall         (stall),
        .i_wb_flush         (flush),
        .i_wb_pc            (pc),
        .i_wb_data_o_ma     (mem),
        .i_wb_alu_rslt      (alu),
        .i_wb_cntrl         (cntrl),
        .i_wb_rdst          (rdst),
        .o_wb_rdst          (o_wb_rdst),
        .o_wb_reg_write_rf  (o_wb_reg_write_rf),
        .o_wb_mux           (o_wb_mux),
        .o_wb_reg_dst_s     (o_wb_reg_dst_s),
        .o_vwb_rdst         (o_vwb_rdst),
        .o_vwb_reg_write_rf (o_vwb_reg_write_rf),
        .o_vwb_mux          (o_vwb_mux),
        .i_fwd_rs           (fwd_rs),
        .o_fwd_hit          (o_fwd_hit),
        .o_fwd_data         (o_fwd_data)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] rdst;
        logic [W-1:0]  data;
    } ent_t;

    ent_t hist[$];   // index 0 = youngest retired entry
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W-1:0] exp_mux();
        case (cntrl[1:0])
            2'b00:   return mem;
            2'b01:   return alu;
            2'b10:   return pc;
            default: return '0;
        endcase
    endfunction

    function automatic bit exp_we();
        return cntrl[2] && valid && (rdst != '0);
    endfunction

    function automatic void exp_fwd(input int k, output bit h, output logic [W-1:0] d);
        logic [N*AW-1:0] all;
        logic [AW-1:0]   rs;
        all = fwd_rs;
        rs  = all[k*AW +: AW];
        h = 1'b0;
        d = '0;
        if (rs == '0) return;
        if (exp_we() && rdst == rs) begin
            h = 1'b1;
            d = exp_mux();
            return;
        end
        foreach (hist[i]) begin
            if (hist[i].we && hist[i].rdst == rs) begin
                h = 1'b1;
                d = hist[i].data;
                return;
            end
        end
    endfunction

    function automatic logic [W-1:0] got_data(input int k);
        logic [N*W-1:0] all;
        all = o_fwd_data;
        return all[k*W +: W];
    endfunction

    // Clock edge plus model update from the inputs sampled at that edge.
    task automatic advance();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            e.we = 1'b0; e.rdst = '0; e.data = '0;
            repeat (D) hist.push_back(e);
        end else if (flush) begin
            foreach (hist[i]) hist[i].we = 1'b0;
        end else if (!stall) begin
            e.we = exp_we(); e.rdst = rdst; e.data = exp_mux();
            hist.push_front(e);
            if (hist.size() > D) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; cntrl = 3'b101; alu = 32'hDEAD; rdst = 5'd9;
        fwd_rs = {5'd9, 5'd9};
        @(negedge clk);
        n_tests++; if (o_wb_mux !== 32'hDEAD) begin n_fail++; $display("FAIL rst_comb_mux got=%h exp=%h", o_wb_mux, 32'hDEAD); end
        n_tests++; if (o_wb_reg_write_rf !== 1'b1) begin n_fail++; $display("FAIL rst_comb_we got=%b exp=1", o_wb_reg_write_rf); end
        advance(); advance();
        rst = 1'b0; alu = 32'h1234; rdst = 5'd7; fwd_rs = {5'd6, 5'd2};
        @(negedge clk);
        n_tests++; if (o_vwb_rdst !== 5'd0) begin n_fail++; $display("FAIL rst_vwb_rdst got=%0d exp=0", o_vwb_rdst); end
        n_tests++; if (o_vwb_mux !== 32'd0) begin n_fail++; $display("FAIL rst_vwb_mux got=%h exp=0", o_vwb_mux); end
        n_tests++; if (o_vwb_reg_write_rf !== 1'b0) begin n_fail++; $display("FAIL rst_vwb_we got=%b exp=0", o_vwb_reg_write_rf); end
        n_tests++; if (o_fwd_hit !== 2'b00) begin n_fail++; $display("FAIL rst_fwd_hit got=%b exp=00", o_fwd_hit); end
        n_tests++; if (o_wb_mux !== 32'h1234) begin n_fail++; $display("FAIL alu_mux got=%h exp=1234", o_wb_mux); end
        n_tests++; if (o_wb_reg_write_rf !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%b exp=1", o_wb_reg_write_rf); end
        advance();
        valid = 1'b0;
        @(negedge clk);
        n_tests++; if (o_vwb_rdst !== 5'd7) begin n_fail++; $display("FAIL vwb_rdst got=%0d exp=7", o_vwb_rdst); end
        n_tests++; if (o_vwb_mux !== 32'h1234) begin n_fail++; $display("FAIL vwb_mux got=%h exp=1234", o_vwb_mux); end
        n_tests++; if (o_vwb_reg_write_rf !== 1'b1) begin n_fail++; $display("FAIL vwb_we got=%b exp=1", o_vwb_reg_write_rf); end
        advance();
    endtask

    task automatic test_select();
        logic [1:0]   sels [3];
        logic [W-1:0] exps [3];
        sels = '{2'b00, 2'b10, 2'b11};
        exps = '{32'hAAAA0000, 32'h00000400, 32'h0};
        mem = 32'hAAAA0000; pc = 32'h400; alu = 32'h5555; valid = 1'b1; rdst = 5'd1;
        for (int i = 0; i < 3; i++) begin
            cntrl = {1'b1, sels[i]};
            @(negedge clk);
            n_tests++; if (o_wb_mux !== exps[i]) begin n_fail++; $display("FAIL sel_mux[%0d] got=%h exp=%h", i, o_wb_mux, exps[i]); end
            n_tests++; if (o_wb_reg_dst_s !== sels[i]) begin n_fail++; $display("FAIL sel_dst_s[%0d] got=%b exp=%b", i, o_wb_reg_dst_s, sels[i]); end
            advance();
        end
    endtask

    task automatic test_r0();
        valid = 1'b1; cntrl = 3'b101; alu = 32'h77; rdst = 5'd0; fwd_rs = '0;
        @(negedge clk);
        n_tests++; if (o_wb_reg_write_rf !== 1'b0) begin n_fail++; $display("FAIL r0_we got=%b exp=0", o_wb_reg_write_rf); end
        n_tests++; if (o_fwd_hit !== 2'b00) begin n_fail++; $display("FAIL r0_hit0 got=%b exp=00", o_fwd_hit); end
        advance();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b0; cntrl = 3'($urandom); rdst = 5'd0;
            @(negedge clk);
            n_tests++; if (o_fwd_hit !== 2'b00) begin n_fail++; $display("FAIL r0_hit_later[%0d] got=%b exp=00", i, o_fwd_hit); end
            advance();
        end
    endtask

    task automatic test_youngest();
        logic         vs [5];
        logic [W-1:0] ds [5];
        logic         eh [5];
        logic [W-1:0] ed [5];
        vs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ds = '{32'h11, 32'h22, 32'h0, 32'h0, 32'h0};
        eh = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{32'h11, 32'h22, 32'h22, 32'h22, 32'h0};
        cntrl = 3'b101; rdst = 5'd5; fwd_rs = {5'd6, 5'd5};
        for (int i = 0; i < 5; i++) begin
            valid = vs[i]; alu = ds[i];
            @(negedge clk);
            n_tests++; if (o_fwd_hit[0] !== eh[i]) begin n_fail++; $display("FAIL young_hit[%0d] got=%b exp=%b", i, o_fwd_hit[0], eh[i]); end
            n_tests++; if (got_data(0) !== ed[i]) begin n_fail++; $display("FAIL young_data[%0d] got=%h exp=%h", i, got_data(0), ed[i]); end
            n_tests++; if (o_fwd_hit[1] !== 1'b0) begin n_fail++; $display("FAIL young_p1_hit[%0d] got=%b exp=0", i, o_fwd_hit[1]); end
            advance();
        end
    endtask

    task automatic test_stall_flush();
        valid = 1'b1; cntrl = 3'b101; rdst = 5'd3; alu = 32'h33; stall = 1'b0; flush = 1'b0;
        fwd_rs = {5'd3, 5'd4};
        advance();
        stall = 1'b1; rdst = 5'd4;
        for (int i = 0; i < 3; i++) begin
            alu = 32'(32'h40 + i);
            @(negedge clk);
            n_tests++; if (o_vwb_rdst !== 5'd3 || o_vwb_mux !== 32'h33 || o_vwb_reg_write_rf !== 1'b1) begin
                n_fail++; $display("FAIL stall_vwb[%0d] got=%0d/%h/%b exp=3/33/1", i, o_vwb_rdst, o_vwb_mux, o_vwb_reg_write_rf); end
            n_tests++; if (o_fwd_hit[0] !== 1'b1 || got_data(0) !== alu) begin
                n_fail++; $display("FAIL stall_p0[%0d] got=%b/%h exp=1/%h", i, o_fwd_hit[0], got_data(0), alu); end
            n_tests++; if (o_fwd_hit[1] !== 1'b1 || got_data(1) !== 32'h33) begin
                n_fail++; $display("FAIL stall_p1[%0d] got=%b/%h exp=1/33", i, o_fwd_hit[1], got_data(1)); end
            advance();
        end
        flush = 1'b1;
        advance();
        flush = 1'b0; stall = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_tests++; if (o_vwb_reg_write_rf !== 1'b0) begin n_fail++; $display("FAIL flush_vwb_we got=%b exp=0", o_vwb_reg_write_rf); end
        n_tests++; if (o_fwd_hit !== 2'b00) begin n_fail++; $display("FAIL flush_hit got=%b exp=00", o_fwd_hit); end
        advance();
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; cntrl = 3'b101; rdst = 5'd9; fwd_rs = {5'd9, 5'd9};
        for (int i = 0; i < 3; i++) begin
            alu = 32'(32'h900 + i);
            advance();
        end
        rst = 1'b1; flush = 1'b1; alu = 32'h9FF;
        @(negedge clk);
        n_tests++; if (o_wb_reg_write_rf !== 1'b1 || o_wb_mux !== 32'h9FF) begin
            n_fail++; $display("FAIL rstmid_comb got=%b/%h exp=1/9ff", o_wb_reg_write_rf, o_wb_mux); end
        advance();
        rst = 1'b0; flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_tests++; if (o_vwb_rdst !== 5'd0 || o_vwb_mux !== 32'd0 || o_vwb_reg_write_rf !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_vwb got=%0d/%h/%b exp=0/0/0", o_vwb_rdst, o_vwb_mux, o_vwb_reg_write_rf); end
        n_tests++; if (o_fwd_hit !== 2'b00) begin n_fail++; $display("FAIL rstmid_hit got=%b exp=00", o_fwd_hit); end
        advance();
    endtask

    task automatic test_random();
        bit           eh;
        logic [W-1:0] ed;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            valid = ($urandom_range(0, 3) != 0);
            cntrl = 3'($urandom);
            rdst  = 5'($urandom_range(0, 7));
            mem = $urandom; alu = $urandom; pc = $urandom;
            fwd_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            @(negedge clk);
            n_tests++; if (o_wb_mux !== exp_mux()) begin n_fail++; $display("FAIL rnd_mux[%0d] got=%h exp=%h", c, o_wb_mux, exp_mux()); end
            n_tests++; if (o_wb_reg_write_rf !== exp_we()) begin n_fail++; $display("FAIL rnd_we[%0d] got=%b exp=%b", c, o_wb_reg_write_rf, exp_we()); end
            n_tests++; if (o_wb_rdst !== rdst || o_wb_reg_dst_s !== cntrl[1:0]) begin
                n_fail++; $display("FAIL rnd_pass[%0d] got=%0d/%b exp=%0d/%b", c, o_wb_rdst, o_wb_reg_dst_s, rdst, cntrl[1:0]); end
            n_tests++; if (o_vwb_reg_write_rf !== hist[0].we || o_vwb_rdst !== hist[0].rdst || o_vwb_mux !== hist[0].data) begin
                n_fail++; $display("FAIL rnd_vwb[%0d] got=%b/%0d/%h exp=%b/%0d/%h", c, o_vwb_reg_write_rf, o_vwb_rdst, o_vwb_mux,
                                   hist[0].we, hist[0].rdst, hist[0].data); end
            for (int k = 0; k < N; k++) begin
                exp_fwd(k, eh, ed);
                n_tests++; if (o_fwd_hit[k] !== eh || got_data(k) !== ed) begin
                    n_fail++; $display("FAIL rnd_fwd[%0d] port=%0d got=%b/%h exp=%b/%h", c, k, o_fwd_hit[k], got_data(k), eh, ed); end
            end
            advance();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
        pc = '0; mem = '0; alu = '0; cntrl = '0; rdst = '0; fwd_rs = '0;
        test_reset();
        test_select();
        test_r0();
        test_youngest();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage_wb_hist.md
Name: stage_wb_hist

Overview:
- Parametrised successor to the writeback stage.
- Selects the register-file write data (memory / ALU / PC / zero) and drives the register-file write port.
- Replaces the fixed one-cycle virtual-writeback register with a DEPTH-entry writeback history.
- History supports stall and flush, and serves NRD combinational forwarding lookups to decode/execute, youngest match first.

Parameters:
- WIDTH, 32, data/PC width in bits
- REG_AW, 5, register index width
- DEPTH, 2, writeback history entries (1..8); entry 0 = one cycle late
- NRD, 2, number of forwarding lookup ports
- R0_ZERO, 1, if 1 register 0 is never written, recorded or matched

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- i_wb_valid  in  1  WB slot holds a real instruction
- i_wb_stall  in  1  freeze history this cycle
- i_wb_flush  in  1  invalidate entire history
- i_wb_pc  in  WIDTH  PC of WB instruction
- i_wb_data_o_ma  in  WIDTH  memory read data
- i_wb_alu_rslt  in  WIDTH  ALU result
- i_wb_cntrl  in  3  [1:0] data select, [2] register write request
- i_wb_rdst  in  REG_AW  destination register
- o_wb_rdst  out  REG_AW  register-file write address
- o_wb_reg_write_rf  out  1  register-file write enable
- o_wb_mux  out  WIDTH  register-file write data
- o_wb_reg_dst_s  out  2  copy of i_wb_cntrl[1:0]
- o_vwb_rdst  out  REG_AW  history entry 0 rdst
- o_vwb_reg_write_rf  out  1  history entry 0 write-enable
- o_vwb_mux  out  WIDTH  history entry 0 data
- i_fwd_rs  in  NRD*REG_AW  lookup register indices, port k at [k*REG_AW +: REG_AW]
- o_fwd_hit  out  NRD  lookup k matched
- o_fwd_data  out  NRD*WIDTH  forwarded data for port k

Behaviour:
- Clock and reset: one clock (clk); rst synchronous, active-high.
- Data select (combinational): 00 = i_wb_data_o_ma; 01 = i_wb_alu_rslt; 10 = i_wb_pc; 11 = all zeros.
- Write enable: commit_we = i_wb_cntrl[2] & i_wb_valid & ~(R0_ZERO & rdst==0).
  - o_wb_reg_write_rf = commit_we, combinational, also during stall and flush.
- Pass-through: o_wb_rdst = i_wb_rdst and o_wb_reg_dst_s = i_wb_cntrl[1:0], combinational.
- History: each entry holds {we, rdst, data}.
  - On a rising edge with ~stall and ~flush: entry0 <= {commit_we, i_wb_rdst, o_wb_mux}; entry k <= entry k-1. The last entry is dropped.
  - Bubbles (commit_we=0) shift in as we=0 entries.
- Stall: all entries hold.
- Flush: all entry we <= 0 on that edge; rdst/data unchanged. Flush overrides stall and shift.
- Reset: all entries {0,0,0}, so o_vwb_* = 0 and o_fwd_hit = 0 the cycle after rst. Combinational outputs follow inputs during reset.
  - Reset wins over flush and stall.
- o_vwb_* = entry 0 at all times. With DEPTH=1 this gives the existing one-cycle virtual-writeback timing exactly.
- Forwarding port k (combinational), candidates in priority order: current commit, entry0, ..., entry DEPTH-1.
  - First candidate with we=1 and rdst==rs is selected: hit=1, data = its data.
  - No match: hit=0, data=0.
  - rs==0 with R0_ZERO=1: hit=0.
  - Same register at multiple depths: youngest wins.
- No arithmetic beyond selection; widths are exact, with no extension or truncation.
- Elaboration error if DEPTH<1, DEPTH>8 or NRD<1.

Decomposition:
- Shared pipeline definitions package gains:
  - WB select codes (MEM=2'b00, ALU=2'b01, PC=2'b10, ZERO=2'b11)
  - control bit positions (WB_RDST_MUX=1:0, WB_R_WE=2)
  - history entry struct/width macro
- One natural sub-module, wb_hist_buf: holds the DEPTH-entry shift history with stall/flush/reset and exposes the flattened entries.
- Select mux, write-enable logic and NRD priority lookups stay in stage_wb_hist, as a generate loop over ports.

Test Plan:
- Reset and select:
  - rst=1 for 2 cycles -> o_vwb_* = 0, o_fwd_hit = 0.
  - Then cntrl=3'b101, alu=0x1234, rdst=7, valid=1 -> o_wb_mux=0x1234, o_wb_reg_write_rf=1; next cycle o_vwb_rdst=7, o_vwb_mux=0x1234, o_vwb_reg_write_rf=1.
- Select codes: sel 00/10/11 with mem=0xAAAA0000, pc=0x400 -> o_wb_mux = 0xAAAA0000 / 0x400 / 0.
- R0 suppression: cntrl=3'b101, rdst=0 -> o_wb_reg_write_rf=0; rs=0 lookup -> hit=0 in every later cycle.
- Youngest wins, DEPTH=2:
  - Write r5=0x11, then r5=0x22, then a bubble; rs=5 -> data 0x22.
  - Two bubbles later -> hit=0.
  - Port 1 with rs=6 -> hit=0 throughout.
- Stall/flush:
  - Write r3=0x33, then stall 3 cycles with new commits r4 -> r3 stays in entry0; rs=4 hits only the current commit.
  - Then flush=1 together with stall=1 -> next cycle o_vwb_reg_write_rf=0, all hits 0.
- Reset mid-operation: history full of valid r9 entries, rst for 1 cycle together with flush=1 -> next cycle all entries cleared, o_vwb_rdst=0, o_vwb_mux=0.
